// File: rtl/de0_vga_timing.sv
// de0_vga_timing
//   VGA timing generator for a 1280x1024 raster on a 1688 x 1066 total grid,
//   one pixel per clk_50 edge. Produces registered colour and sync outputs
//   that are mutually aligned one clock behind the counters.
//
// Ports
//   clk_50      in   system/pixel clock
//   reset       in   synchronous active-high reset
//   pixel_color in   {R[11:8], G[7:4], B[3:0]} for the current counter position
//   VGA_BUS_R/G/B out registered colour, forced to 0 outside the active area
//   VGA_HS/VS   out  registered active-high syncs
//   X_pix/Y_pix out  horizontal / vertical counter registers
//   H_visible/V_visible out  combinational active-area flags from the counters
//   pixel_clk   out  clk_50 passed straight through
//   pixel_cnt   out  frame counter, wraps 1023 -> 0
module de0_vga_timing (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [11:0] pixel_color,
  output logic [3:0]  VGA_BUS_R,
  output logic [3:0]  VGA_BUS_G,
  output logic [3:0]  VGA_BUS_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [10:0] X_pix,
  output logic [10:0] Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic        pixel_clk,
  output logic [9:0]  pixel_cnt
);

  localparam logic [10:0] H_ACTIVE = 11'd1280;
  localparam logic [10:0] H_SYNC_S = 11'd1328;
  localparam logic [10:0] H_SYNC_E = 11'd1439;
  localparam logic [10:0] H_LAST   = 11'd1687;

  localparam logic [10:0] V_ACTIVE = 11'd1024;
  localparam logic [10:0] V_SYNC_S = 11'd1025;
  localparam logic [10:0] V_SYNC_E = 11'd1027;
  localparam logic [10:0] V_LAST   = 11'd1065;

  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic [9:0]  frame_cnt;
  logic        x_wrap;
  logic        frame_wrap;

  assign x_wrap     = (x_cnt == H_LAST);
  assign frame_wrap = x_wrap && (y_cnt == V_LAST);

  assign X_pix     = x_cnt;
  assign Y_pix     = y_cnt;
  assign H_visible = (x_cnt < H_ACTIVE);
  assign V_visible = (y_cnt < V_ACTIVE);
  assign pixel_cnt = frame_cnt;
  assign pixel_clk = clk_50;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      frame_cnt <= '0;
      VGA_BUS_R <= '0;
      VGA_BUS_G <= '0;
      VGA_BUS_B <= '0;
      VGA_HS    <= 1'b0;
      VGA_VS    <= 1'b0;
    end else begin
      if (x_wrap) begin
        x_cnt <= '0;
        if (y_cnt == V_LAST) begin
          y_cnt <= '0;
        end else begin
          y_cnt <= y_cnt + 11'd1;
        end
      end else begin
        x_cnt <= x_cnt + 11'd1;
      end

      // Frame counter relies on natural 10-bit rollover for 1023 -> 0.
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 10'd1;
      end

      // Colour and syncs are decoded from the same counter state, so they
      // emerge together one clock after the position they describe.
      if (H_visible && V_visible) begin
        VGA_BUS_R <= pixel_color[11:8];
        VGA_BUS_G <= pixel_color[7:4];
        VGA_BUS_B <= pixel_color[3:0];
      end else begin
        VGA_BUS_R <= '0;
        VGA_BUS_G <= '0;
        VGA_BUS_B <= '0;
      end

      VGA_HS <= (x_cnt >= H_SYNC_S) && (x_cnt <= H_SYNC_E);
      VGA_VS <= (y_cnt >= V_SYNC_S) && (y_cnt <= V_SYNC_E);
    end
  end

endmodule

// File: tb/tb_de0_vga_timing.sv
// tb_de0_vga_timing
//   Directed bench for de0_vga_timing. Inputs are driven and outputs sampled
//   on the falling edge. Long vertical stretches are skipped by briefly
//   forcing the counter registers to a chosen position.
module tb_de0_vga_timing;

  logic        clk_50;
  logic        reset;
  logic [11:0] pixel_color;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic [10:0] x_pix;
  logic [10:0] y_pix;
  logic        h_visible;
  logic        v_visible;
  logic        pixel_clk;
  logic [9:0]  pixel_cnt;

  int checks = 0;
  int errors = 0;

  de0_vga_timing dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .pixel_color (pixel_color),
    .VGA_BUS_R   (vga_r),
    .VGA_BUS_G   (vga_g),
    .VGA_BUS_B   (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .X_pix       (x_pix),
    .Y_pix       (y_pix),
    .H_visible   (h_visible),
    .V_visible   (v_visible),
    .pixel_clk   (pixel_clk),
    .pixel_cnt   (pixel_cnt)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic tick();
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [11:0] exp);
    check(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
  endtask

  // Place the raster at (x, y); the next edge advances from there.
  task automatic jump(input logic [10:0] x, input logic [10:0] y);
    force dut.x_cnt = x;
    force dut.y_cnt = y;
    #1;
    release dut.x_cnt;
    release dut.y_cnt;
  endtask

  task automatic run_to(input string tag, input logic [10:0] x, input logic [10:0] y,
                        input int bound);
    int n = 0;
    while ((x_pix !== x || y_pix !== y) && n < bound) begin
      tick();
      n++;
    end
    check(tag, {10'd0, x_pix, y_pix}, {10'd0, x, y});
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    pixel_color = 12'h000;

    // Reset held for three edges.
    repeat (3) @(posedge clk_50);
    #1;
    check("pixclk_hi", {31'd0, pixel_clk}, 32'd1);
    @(negedge clk_50);
    check("pixclk_lo", {31'd0, pixel_clk}, 32'd0);
    check("rst_x", {21'd0, x_pix}, 32'd0);
    check("rst_y", {21'd0, y_pix}, 32'd0);
    check_rgb("rst_rgb", 12'h000);
    check("rst_hs", {31'd0, vga_hs}, 32'd0);
    check("rst_vs", {31'd0, vga_vs}, 32'd0);
    check("rst_cnt", {22'd0, pixel_cnt}, 32'd0);
    check("rst_hvis", {31'd0, h_visible}, 32'd1);
    check("rst_vvis", {31'd0, v_visible}, 32'd1);

    reset = 1'b0;
    tick();
    check("first_x", {21'd0, x_pix}, 32'd1);
    check("first_y", {21'd0, y_pix}, 32'd0);

    // Colour pass-through, one clock latency.
    pixel_color = 12'hABC;
    tick();
    check_rgb("rgb_abc", 12'hABC);
    pixel_color = 12'h123;
    tick();
    check_rgb("rgb_123", 12'h123);

    // Line timing and horizontal blanking.
    pixel_color = 12'hABC;
    run_to("reach_1279", 11'd1279, 11'd0, 2000);
    check("hvis_1279", {31'd0, h_visible}, 32'd1);
    tick();
    check("hvis_1280", {31'd0, h_visible}, 32'd0);
    check_rgb("rgb_last_vis", 12'hABC);
    tick();
    check_rgb("rgb_hblank", 12'h000);
    run_to("reach_1328", 11'd1328, 11'd0, 100);
    check("hs_before", {31'd0, vga_hs}, 32'd0);
    tick();
    check("hs_rise", {31'd0, vga_hs}, 32'd1);
    n = 0;
    while (vga_hs === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("hs_width", n, 32'd112);
    check("hs_end_x", {21'd0, x_pix}, 32'd1441);
    run_to("reach_1687", 11'd1687, 11'd0, 300);
    tick();
    check("line_wrap", {10'd0, x_pix, y_pix}, {10'd0, 11'd0, 11'd1});
    tick();
    check_rgb("rgb_line1", 12'hABC);

    // Vertical blanking.
    jump(11'd1687, 11'd1023);
    tick();
    check("vvis_1024", {31'd0, v_visible}, 32'd0);
    check("hvis_x0", {31'd0, h_visible}, 32'd1);
    tick();
    check_rgb("rgb_vblank", 12'h000);

    // Vertical sync.
    run_to("reach_vs", 11'd0, 11'd1025, 4000);
    check("vs_before", {31'd0, vga_vs}, 32'd0);
    tick();
    check("vs_rise", {31'd0, vga_vs}, 32'd1);
    n = 0;
    while (vga_vs === 1'b1 && n < 6000) begin
      n++;
      tick();
    end
    check("vs_width", n, 32'd5064);
    check("vs_end", {10'd0, x_pix, y_pix}, {10'd0, 11'd1, 11'd1028});

    // Frame counter rollover 1023 -> 0.
    force dut.frame_cnt = 10'd1023;
    jump(11'd1687, 11'd1065);
    release dut.frame_cnt;
    tick();
    check("cnt_roll", {22'd0, pixel_cnt}, 32'd0);
    check("frame_wrap_pos", {10'd0, x_pix, y_pix}, 32'd0);

    // Normal frame wrap 0 -> 1.
    jump(11'd1680, 11'd1065);
    run_to("reach_end", 11'd1687, 11'd1065, 20);
    check("cnt_pre", {22'd0, pixel_cnt}, 32'd0);
    tick();
    check("cnt_inc", {22'd0, pixel_cnt}, 32'd1);
    check("y_back0", {21'd0, y_pix}, 32'd0);

    // Mid-frame reset.
    jump(11'd690, 11'd500);
    run_to("reach_mid", 11'd700, 11'd500, 20);
    check_rgb("rgb_mid", 12'hABC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_pos", {10'd0, x_pix, y_pix}, 32'd0);
    check_rgb("mid_rgb", 12'h000);
    check("mid_cnt", {22'd0, pixel_cnt}, 32'd0);
    tick();
    check("mid_restart", {10'd0, x_pix, y_pix}, {10'd0, 11'd1, 11'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
